// File: rtl/conv_window_gen.sv
// conv_window_gen
// ---------------
// Streaming K_SIZE x K_SIZE window generator feeding the conv2d datapath.
// Raster-order signed pixels arrive over a valid/ready handshake. K_SIZE-1
// line buffers and a K_SIZE-column shift register assemble the window. One
// window is emitted for every position whose window lies fully inside the
// image, so there is no padding. The window is held in a registered output
// slice that supports backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous frame restart (counters to 0, output window dropped)
//   in_valid   pixel present on in_pix
//   in_ready   block can accept a pixel this cycle
//   in_pix     signed pixel, raster order, line 0 col 0 first
//   win_valid  window present on windowImg
//   win_ready  consumer takes the window this cycle
//   windowImg  [r][c] = pixel(row0+r, col0+c)
//   win_last   (only with CONV_WINDOW_GEN_LAST_EN) window ends at the last pixel of the frame
//   busy       frame in progress (column or row counter nonzero)
//
// Optional feature macro: CONV_WINDOW_GEN_LAST_EN adds the win_last output.

module conv_window_gen #(
  parameter int K_SIZE = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PIX_W  = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [PIX_W-1:0] in_pix,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic signed [PIX_W-1:0] windowImg [0:K_SIZE-1][0:K_SIZE-1],
`ifdef CONV_WINDOW_GEN_LAST_EN
  output logic                    win_last,
`endif
  output logic                    busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K_SIZE - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_ZERO = CW'(0);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K_SIZE - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_ZERO = RW'(0);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;

  // Line buffers: lb_r[0] holds the previous line and lb_r[K_SIZE-2] the oldest one.
  logic signed [PIX_W-1:0] lb_r       [0:K_SIZE-2][0:IMG_W-1];
  logic signed [PIX_W-1:0] sr_r       [0:K_SIZE-1][0:K_SIZE-1];
  logic signed [PIX_W-1:0] col_vec_s  [0:K_SIZE-1];
  logic signed [PIX_W-1:0] win_next_s [0:K_SIZE-1][0:K_SIZE-1];

  logic fire_s;
  logic emit_s;
  logic last_pix_s;

  // The output slice can take a new window when it is empty or being drained.
  assign in_ready = ~win_valid | win_ready;

  // A pixel that arrives while clr is high is not accepted.
  assign fire_s     = in_valid & in_ready & ~clr;
  assign last_pix_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
  assign emit_s     = fire_s && (row_r >= ROW_WIN) && (col_r >= COL_WIN);
  assign busy       = (col_r != COL_ZERO) || (row_r != ROW_ZERO);

  // Column vector for the current column, oldest line first and the incoming pixel last.
  always_comb begin
    for (int r = 0; r < K_SIZE - 1; r++) begin
      col_vec_s[r] = lb_r[K_SIZE-2-r][col_r];
    end
    col_vec_s[K_SIZE-1] = in_pix;
  end

  // Next shift-register contents: shift left one column and insert the new column on the right.
  always_comb begin
    for (int r = 0; r < K_SIZE; r++) begin
      for (int c = 0; c < K_SIZE - 1; c++) begin
        win_next_s[r][c] = sr_r[r][c+1];
      end
      win_next_s[r][K_SIZE-1] = col_vec_s[r];
    end
  end

  // Raster position counters. Both wrap together on the last pixel so the next frame starts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= COL_ZERO;
      row_r <= ROW_ZERO;
    end else if (clr) begin
      col_r <= COL_ZERO;
      row_r <= ROW_ZERO;
    end else if (fire_s) begin
      if (col_r == COL_LAST) begin
        col_r <= COL_ZERO;
        row_r <= (row_r == ROW_LAST) ? ROW_ZERO : row_r + ROW_ONE;
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  // Chained line-buffer storage. Contents are don't-care after reset, so this RAM has no reset.
  always_ff @(posedge clk) begin
    if (fire_s) begin
      lb_r[0][col_r] <= in_pix;
      for (int i = 1; i < K_SIZE - 1; i++) begin
        lb_r[i][col_r] <= lb_r[i-1][col_r];
      end
    end
  end

  // Window shift register. Stale columns are flushed by the leading columns of each line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K_SIZE; r++) begin
        for (int c = 0; c < K_SIZE; c++) begin
          sr_r[r][c] <= '0;
        end
      end
    end else if (fire_s) begin
      sr_r <= win_next_s;
    end
  end

  // Registered output slice. Loading a new window and consuming the old one can share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      for (int r = 0; r < K_SIZE; r++) begin
        for (int c = 0; c < K_SIZE; c++) begin
          windowImg[r][c] <= '0;
        end
      end
`ifdef CONV_WINDOW_GEN_LAST_EN
      win_last <= 1'b0;
`endif
    end else if (clr) begin
      win_valid <= 1'b0;
`ifdef CONV_WINDOW_GEN_LAST_EN
      win_last <= 1'b0;
`endif
    end else if (emit_s) begin
      win_valid <= 1'b1;
      windowImg <= win_next_s;
`ifdef CONV_WINDOW_GEN_LAST_EN
      win_last <= last_pix_s;
`endif
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

`ifndef CONV_WINDOW_GEN_LAST_EN
  // Only win_last uses the last-pixel flag, so it is otherwise unconnected.
  logic unused_s;
  assign unused_s = last_pix_s;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen (K=3, 5x4 image). A driver issues pixels and
// pushes the expected window into a scoreboard queue. A separate monitor pops
// and compares each window the DUT hands over, and it also checks that the
// window stays stable under backpressure.
module tb_conv_window_gen;
  localparam int K = 3;
  localparam int W = 5;
  localparam int H = 4;
  localparam int P = 9;
  localparam int NB = K * K * P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [P-1:0] in_pix = '0;
  logic win_valid;
  logic win_ready = 1'b1;
  logic signed [P-1:0] win_img [0:K-1][0:K-1];
  logic busy;
`ifdef CONV_WINDOW_GEN_LAST_EN
  logic win_last;
`endif

  conv_window_gen #(.K_SIZE(K), .IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .win_valid(win_valid), .win_ready(win_ready), .windowImg(win_img),
`ifdef CONV_WINDOW_GEN_LAST_EN
    .win_last(win_last),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] img;
    logic          last;
  } exp_t;

  exp_t            sbq[$];
  logic [NB-1:0]   got[$];
  logic signed [P-1:0] fimg [0:H-1][0:W-1];
  int n_cmp = 0;
  int n_bad = 0;
  int brow = 0;
  int bcol = 0;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] pack_dut();
    logic [NB-1:0] v;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*P +: P] = win_img[r][c];
    return v;
  endfunction

  function automatic logic [NB-1:0] win_of(input int r0, input int c0);
    logic [NB-1:0] v;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*P +: P] = fimg[r0-K+1+r][c0-K+1+c];
    return v;
  endfunction

  // Hand-written window, row-major.
  function automatic logic [NB-1:0] hw(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
    int a[9];
    logic [NB-1:0] v;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    for (int k = 0; k < 9; k++) v[k*P +: P] = P'(a[k]);
    return v;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fimg[r][c] = (mode == 1) ? P'($urandom) : P'(r * 16 + c);
  endtask

  // Monitor: pops expected windows on each handshake and checks hold stability.
  initial begin
    logic hold;
    logic [NB-1:0] held;
    exp_t e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", {{(NB-1){1'b0}}, win_valid}, {{(NB-1){1'b0}}, 1'b1});
          chk("hold_window", pack_dut(), held);
        end
        if (win_valid && win_ready) begin
          got.push_back(pack_dut());
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_window: got %h expected none", pack_dut());
          end else begin
            e = sbq.pop_front();
            chk("window", pack_dut(), e.img);
`ifdef CONV_WINDOW_GEN_LAST_EN
            chk("win_last", {{(NB-1){1'b0}}, win_last}, {{(NB-1){1'b0}}, e.last});
`endif
          end
        end
        hold = win_valid && !win_ready && !clr;
        held = pack_dut();
      end
    end
  end

  // mode 0: always valid/ready; 1: random 50%; 2: 4-cycle stall after first window;
  // 3: like 0 but leaves the final window held (win_ready=0).
  task automatic run(input int n_pix, input int mode, input int clr_at);
    int sent, cyc, stall_left;
    bit stall_done, exp_next, clr_hit;
    exp_t e;
    sent = 0; cyc = 0; stall_left = 0; stall_done = 0; exp_next = 0; clr_hit = 0;
    if (brow == 0 && bcol == 0) fill(mode);
    while (sent < n_pix && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 0 || mode == 3)
        chk("valid_latency", {{(NB-1){1'b0}}, win_valid}, {{(NB-1){1'b0}}, exp_next});
      exp_next = 0;
      in_valid = 1'b1;
      win_ready = 1'b1;
      if (mode == 1) begin
        in_valid = 1'($urandom_range(0, 1));
        win_ready = 1'($urandom_range(0, 1));
      end
      if (mode == 2) begin
        if (!stall_done && win_valid) begin
          stall_left = 4;
          stall_done = 1;
        end
        if (stall_left > 0) win_ready = 1'b0;
      end
      in_pix = fimg[brow][bcol];
      clr = (sent == clr_at);
      #1;
      if (stall_left > 0) begin
        stall_left--;
        chk("stall_in_ready", {{(NB-1){1'b0}}, in_ready}, '0);
        chk("stall_window", pack_dut(), hw(0, 1, 2, 16, 17, 18, 32, 33, 34));
      end
      if (clr) begin
        clr_hit = 1;
        brow = 0;
        bcol = 0;
        sent = n_pix;
      end else if (in_valid && in_ready) begin
        if (brow >= K - 1 && bcol >= K - 1) begin
          e.img = win_of(brow, bcol);
          e.last = (brow == H - 1) && (bcol == W - 1);
          sbq.push_back(e);
          exp_next = 1;
        end
        sent++;
        if (bcol == W - 1) begin
          bcol = 0;
          if (brow == H - 1) begin
            brow = 0;
            fill(mode);
          end else begin
            brow++;
          end
        end else begin
          bcol++;
        end
      end
    end
    if (cyc >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got %0d pixels expected %0d", sent, n_pix);
    end
    @(posedge clk); #1;
    if (clr_hit) begin
      chk("clr_valid", {{(NB-1){1'b0}}, win_valid}, '0);
      chk("clr_busy", {{(NB-1){1'b0}}, busy}, '0);
      clr = 1'b0;
    end else if (mode == 0 || mode == 3) begin
      chk("valid_latency", {{(NB-1){1'b0}}, win_valid}, {{(NB-1){1'b0}}, exp_next});
    end
    in_valid = 1'b0;
    win_ready = (mode != 3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    win_ready = 1'b1;
    while ((sbq.size() != 0 || win_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  initial begin
    int b;
    #12;
    chk("reset_valid", {{(NB-1){1'b0}}, win_valid}, '0);
    chk("reset_busy", {{(NB-1){1'b0}}, busy}, '0);
    chk("reset_window", pack_dut(), '0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {{(NB-1){1'b0}}, in_ready}, {{(NB-1){1'b0}}, 1'b1});

    // One frame at full rate.
    b = got.size();
    run(20, 0, -1);
    drain();
    chk("frame1_count", NB'(got.size() - b), NB'(6));
    chk("frame1_first", got[b], hw(0, 1, 2, 16, 17, 18, 32, 33, 34));
    chk("frame1_last", got[b+5], hw(18, 19, 20, 34, 35, 36, 50, 51, 52));

    // Backpressure after the first window.
    b = got.size();
    run(20, 2, -1);
    drain();
    chk("stall_count", NB'(got.size() - b), NB'(6));
    chk("stall_first", got[b], hw(0, 1, 2, 16, 17, 18, 32, 33, 34));
    chk("stall_second", got[b+1], hw(1, 2, 3, 17, 18, 19, 33, 34, 35));

    // Two frames back to back.
    b = got.size();
    run(40, 0, -1);
    drain();
    chk("b2b_count", NB'(got.size() - b), NB'(12));
    chk("b2b_first2", got[b+6], hw(0, 1, 2, 16, 17, 18, 32, 33, 34));
    chk("b2b_last2", got[b+11], hw(18, 19, 20, 34, 35, 36, 50, 51, 52));

    // Random handshakes over three frames with random pixel values.
    b = got.size();
    run(60, 1, -1);
    drain();
    chk("random_count", NB'(got.size() - b), NB'(18));

    // Frame restart at pixel 8, then a fresh frame.
    run(20, 0, 8);
    b = got.size();
    run(20, 0, -1);
    drain();
    chk("after_clr_count", NB'(got.size() - b), NB'(6));
    chk("after_clr_first", got[b], hw(0, 1, 2, 16, 17, 18, 32, 33, 34));

    // Asynchronous reset while a window is held.
    run(13, 3, -1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {{(NB-1){1'b0}}, win_valid}, '0);
    chk("async_rst_window", pack_dut(), '0);
    chk("async_rst_busy", {{(NB-1){1'b0}}, busy}, '0);
    #2;
    rst_n = 1'b1;
    sbq.delete();
    brow = 0;
    bcol = 0;
    win_ready = 1'b1;
    b = got.size();
    run(20, 0, -1);
    drain();
    chk("post_rst_count", NB'(got.size() - b), NB'(6));
    chk("post_rst_last", got[b+5], hw(18, 19, 20, 34, 35, 36, 50, 51, 52));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
